// File: rtl/hs32_mem_arbiter.sv
// hs32 memory arbiter: shares one external memory port between the fetch unit
// (read-only) and the execute unit (read/write). Execute has fixed priority; a
// starvation counter guarantees fetch progress. Flush suppresses fetch delivery.
module hs32_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned SBITS        = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    // fetch side
    input  logic [31:0] f_addr,
    input  logic        f_reqm,
    output logic [31:0] f_dtr,
    output logic        f_ackm,
    // execute side
    input  logic [31:0] x_addr,
    input  logic [31:0] x_dtw,
    input  logic        x_rw,
    input  logic        x_reqm,
    output logic [31:0] x_dtr,
    output logic        x_ackm,
    // pipeline flush
    input  logic        flush,
    // memory side
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    output logic        m_rw,
    output logic        m_req,
    input  logic [31:0] m_dtr,
    input  logic        m_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_X} owner_t;

    localparam logic [SBITS-1:0] LIMIT = SBITS'(STARVE_LIMIT);

    state_t           state;
    owner_t           owner;
    logic [SBITS-1:0] starve_cnt;
    logic [31:0]      rdata;
    logic             f_ack_q;
    logic             x_ack_q;
    logic             kill;

    logic f_ok;
    logic at_limit;
    logic grant_f;
    logic grant_x;

    // Arbitration decision for the IDLE cycle; flush blocks a fetch grant.
    always_comb begin
        f_ok     = f_reqm && !flush;
        at_limit = (starve_cnt == LIMIT);
        grant_f  = f_ok && (!x_reqm || at_limit);
        grant_x  = x_reqm && !grant_f;
    end

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            rdata      <= '0;
            f_ack_q    <= 1'b0;
            x_ack_q    <= 1'b0;
            kill       <= 1'b0;
            m_addr     <= '0;
            m_dtw      <= '0;
            m_rw       <= 1'b0;
            m_req      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_f) begin
                        m_addr     <= f_addr;
                        m_dtw      <= '0;
                        m_rw       <= 1'b0;
                        m_req      <= 1'b1;
                        owner      <= OWN_F;
                        starve_cnt <= '0;
                        kill       <= 1'b0;
                        state      <= BUSY;
                    end else if (grant_x) begin
                        m_addr <= x_addr;
                        m_dtw  <= x_dtw;
                        m_rw   <= x_rw;
                        m_req  <= 1'b1;
                        owner  <= OWN_X;
                        state  <= BUSY;
                        // Count execute wins only while fetch is actually waiting.
                        if (f_ok) begin
                            starve_cnt <= at_limit ? starve_cnt : starve_cnt + SBITS'(1);
                        end else if (!f_reqm) begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (flush && owner == OWN_F) begin
                        kill <= 1'b1;
                    end
                    if (m_ack) begin
                        rdata   <= m_dtr;
                        m_req   <= 1'b0;
                        f_ack_q <= (owner == OWN_F) && !kill && !flush;
                        x_ack_q <= (owner == OWN_X);
                        state   <= RESP;
                    end
                end
                RESP: begin
                    f_ack_q <= 1'b0;
                    x_ack_q <= 1'b0;
                    kill    <= 1'b0;
                    owner   <= OWN_NONE;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A flush landing in the response cycle still discards the fetch result.
    assign f_ackm = f_ack_q && !flush;
    assign x_ackm = x_ack_q;
    assign f_dtr  = rdata;
    assign x_dtr  = rdata;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Self-checking bench for hs32_mem_arbiter: transaction-level reference model,
// scoreboard queues and a decoupled monitor, with directed and random phases.
module tb_hs32_mem_arbiter;

    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] f_addr, f_dtr, x_addr, x_dtw, x_dtr, m_addr, m_dtw, m_dtr;
    logic        f_reqm, f_ackm, x_rw, x_reqm, x_ackm, flush, m_rw, m_req, m_ack;

    hs32_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .SBITS(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_addr(f_addr), .f_reqm(f_reqm), .f_dtr(f_dtr), .f_ackm(f_ackm),
        .x_addr(x_addr), .x_dtw(x_dtw), .x_rw(x_rw), .x_reqm(x_reqm),
        .x_dtr(x_dtr), .x_ackm(x_ackm), .flush(flush),
        .m_addr(m_addr), .m_dtw(m_dtw), .m_rw(m_rw), .m_req(m_req),
        .m_dtr(m_dtr), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_f;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] dtw;
    } txn_t;

    typedef struct {
        bit          is_f;
        bit          rw;
        logic [31:0] data;
        bit          killed;
    } ack_t;

    txn_t txn_q[$];
    ack_t ack_q[$];
    bit   grants[$];

    int checks = 0;
    int errors = 0;
    int n_acks = 0;

    int          fixed_delay = -1;
    bit          dir_data_en = 1'b0;
    logic [31:0] dir_data    = '0;
    bit          f_ack_seen  = 1'b0;
    bit          x_ack_seen  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event at %0t", nm, $time);
    endtask

    // Reference model: grant decisions and delivery expectations per transaction.
    initial begin
        int  phase;
        int  cnt;
        bit  cur_f;
        bit  cur_rw;
        bit  killed;
        bit  fok;
        txn_t t;
        ack_t a;
        phase = 0; cnt = 0; cur_f = 0; cur_rw = 0; killed = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                phase = 0;
                cnt   = 0;
                killed = 0;
                txn_q.delete();
                ack_q.delete();
            end else begin
                fok = f_reqm && !flush;
                if (phase == 0) begin
                    if (x_reqm && !(fok && cnt == STARVE_LIMIT)) begin
                        t.is_f = 0; t.addr = x_addr; t.rw = x_rw; t.dtw = x_dtw;
                        txn_q.push_back(t);
                        cur_f = 0; cur_rw = x_rw; phase = 1;
                        if (fok) cnt = (cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : cnt + 1;
                        else if (!f_reqm) cnt = 0;
                    end else if (fok) begin
                        t.is_f = 1; t.addr = f_addr; t.rw = 0; t.dtw = 0;
                        txn_q.push_back(t);
                        cur_f = 1; cur_rw = 0; killed = 0; phase = 1; cnt = 0;
                    end
                end else if (phase == 1) begin
                    if (flush && cur_f) killed = 1;
                    if (m_ack) begin
                        a.is_f = cur_f; a.rw = cur_rw; a.data = m_dtr; a.killed = killed;
                        ack_q.push_back(a);
                        phase = 2;
                    end
                end else begin
                    phase = 0;
                    killed = 0;
                end
            end
        end
    end

    // Memory responder: acks after a chosen number of waiting cycles.
    initial begin
        bit mem_busy;
        int mem_cnt;
        mem_busy = 0; mem_cnt = 0;
        m_ack = 1'b0; m_dtr = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_ack = 1'b0;
                mem_busy = 0;
            end else begin
                #1;
                m_ack = 1'b0;
                if (!mem_busy && m_req && reset_n) begin
                    mem_busy = 1;
                    mem_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                end
                if (mem_busy) begin
                    if (mem_cnt == 0) begin
                        m_ack = 1'b1;
                        m_dtr = dir_data_en ? dir_data : $urandom;
                        mem_busy = 0;
                    end else begin
                        mem_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a grant or a response.
    initial begin
        logic        prev_req;
        logic [31:0] cap_addr, cap_dtw;
        logic        cap_rw;
        txn_t        t;
        ack_t        a;
        bit          exp_f, exp_x;
        prev_req = 0; cap_addr = '0; cap_dtw = '0; cap_rw = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req = 0;
                f_ack_seen = 0;
                x_ack_seen = 0;
            end else begin
                if (f_ackm && x_ackm) begin
                    checks++; errors++;
                    $display("FAIL ack_exclusive actual=both required=at_most_one at %0t", $time);
                end
                if (m_req && !prev_req) begin
                    if (txn_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_grant actual=addr_%h required=none at %0t",
                                 m_addr, $time);
                    end else begin
                        t = txn_q.pop_front();
                        chk("grant_addr", m_addr, t.addr);
                        chk("grant_rw", 32'(m_rw), 32'(t.rw));
                        chk("grant_dtw", m_dtw, t.dtw);
                        grants.push_back(t.is_f);
                    end
                    cap_addr = m_addr; cap_dtw = m_dtw; cap_rw = m_rw;
                end else if (m_req && prev_req) begin
                    chk("stable_addr", m_addr, cap_addr);
                    chk("stable_dtw", m_dtw, cap_dtw);
                    chk("stable_rw", 32'(m_rw), 32'(cap_rw));
                end
                if (ack_q.size() > 0) begin
                    a = ack_q.pop_front();
                    exp_f = a.is_f && !a.killed && !flush;
                    exp_x = !a.is_f;
                    chk("f_ackm", 32'(f_ackm), 32'(exp_f));
                    chk("x_ackm", 32'(x_ackm), 32'(exp_x));
                    if (exp_f) chk("f_dtr", f_dtr, a.data);
                    if (exp_x && !a.rw) chk("x_dtr", x_dtr, a.data);
                    if (exp_f || exp_x) n_acks++;
                end else if (f_ackm || x_ackm) begin
                    checks++; errors++;
                    $display("FAIL spurious_ack actual=f%0d_x%0d required=none at %0t",
                             f_ackm, x_ackm, $time);
                end
                prev_req   = m_req;
                f_ack_seen = f_ackm;
                x_ack_seen = x_ackm;
            end
        end
    end

    task automatic wait_ack(input bit want_f, input string nm);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            got = want_f ? f_ack_seen : x_ack_seen;
            n++;
        end
        if (!got) fail_now(nm);
    endtask

    task automatic hold_both();
        x_addr = 32'h200; x_rw = 1'b0; x_dtw = 32'h0;
        f_addr = 32'h300;
        x_reqm = 1'b1; f_reqm = 1'b1;
    endtask

    task automatic check_seq(input string nm);
        bit exp_seq [8];
        int n;
        exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
        n = 0;
        while (grants.size() < 8 && n < 200) begin
            @(posedge clk); n++;
        end
        #1;
        x_reqm = 1'b0; f_reqm = 1'b0;
        if (grants.size() < 8) fail_now(nm);
        else for (int i = 0; i < 8; i++) chk(nm, 32'(grants[i]), 32'(exp_seq[i]));
        repeat (15) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int fcount;
        reset_n = 1'b1;
        f_addr = '0; f_reqm = 0; x_addr = '0; x_dtw = '0; x_rw = 0; x_reqm = 0; flush = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_rw", 32'(m_rw), 0);
        chk("rst_f_ackm", 32'(f_ackm), 0);
        chk("rst_x_ackm", 32'(x_ackm), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_dtw", m_dtw, 0);
        chk("rst_f_dtr", f_dtr, 0);
        chk("rst_x_dtr", x_dtr, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single fetch with known read data.
        dir_data_en = 1; dir_data = 32'hDEADBEEF;
        f_addr = 32'h10; f_reqm = 1;
        @(negedge clk); chk("fetch_req_n", 32'(m_req), 0);
        @(negedge clk); chk("fetch_req_n1", 32'(m_req), 1);
        chk("fetch_addr", m_addr, 32'h10);
        chk("fetch_rw", 32'(m_rw), 0);
        wait_ack(1, "fetch_ack");
        f_reqm = 0; dir_data_en = 0;

        // Execute write.
        fixed_delay = 2;
        x_rw = 1; x_addr = 32'h100; x_dtw = 32'h12345678; x_reqm = 1;
        @(negedge clk); @(negedge clk);
        chk("xw_rw", 32'(m_rw), 1);
        chk("xw_dtw", m_dtw, 32'h12345678);
        chk("xw_addr", m_addr, 32'h100);
        wait_ack(0, "xw_ack");
        x_reqm = 0; x_rw = 0; fixed_delay = -1;

        // Starvation guard with both requesters held high.
        grants.delete();
        hold_both();
        check_seq("starve_seq");

        // Flush while a fetch is in flight.
        fixed_delay = 3;
        f_addr = 32'h20; f_reqm = 1;
        @(posedge clk); #1;
        flush = 1; f_reqm = 0;
        @(posedge clk); #1;
        flush = 0;
        fcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (f_ackm) fcount++;
        end
        chk("flush_no_ack", 32'(fcount), 0);
        fixed_delay = -1;
        @(posedge clk); #1;
        x_addr = 32'h40; x_rw = 0; x_reqm = 1;
        wait_ack(0, "after_flush_ack");
        x_reqm = 0;

        // Slow memory: outputs must hold while waiting.
        fixed_delay = 5;
        x_addr = 32'h80; x_dtw = 32'hA5A5A5A5; x_rw = 1; x_reqm = 1;
        wait_ack(0, "slow_ack");
        x_reqm = 0; x_rw = 0;

        // Reset in BUSY after the counter has climbed.
        grants.delete();
        hold_both();
        n = 0;
        while (grants.size() < 3 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (grants.size() < 3) fail_now("pre_reset_grants");
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_m_req", 32'(m_req), 0);
        chk("async_f_ackm", 32'(f_ackm), 0);
        chk("async_x_ackm", 32'(x_ackm), 0);
        chk("async_m_addr", m_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        fixed_delay = -1;
        grants.delete();
        reset_n = 1'b1;
        check_seq("post_reset_seq");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            flush = 0;
            if (f_ack_seen) f_reqm = 0;
            else if (!f_reqm && $urandom_range(0, 2) == 0) begin
                f_addr = $urandom & ~32'd3;
                f_reqm = 1;
            end
            if (x_ack_seen) x_reqm = 0;
            else if (!x_reqm && $urandom_range(0, 2) == 0) begin
                x_addr = $urandom & ~32'd3;
                x_dtw  = $urandom;
                x_rw   = 1'($urandom_range(0, 1));
                x_reqm = 1;
            end
            if ($urandom_range(0, 15) == 0) begin
                flush = 1;
                if ($urandom_range(0, 1) == 1) f_reqm = 0;
            end
        end
        @(posedge clk); #1;
        f_reqm = 0; x_reqm = 0; flush = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("txn_q_drained", 32'(txn_q.size()), 0);
        chk("ack_q_drained", 32'(ack_q.size()), 0);
        chk("enough_acks", 32'(n_acks > 100), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
